// File: rtl/controller_pkg.sv
// Shared constants for the 2A03 controller-port responder: bus addresses,
// button bit positions and the open-bus filler for read data.
package controller_pkg;

  localparam logic [15:0] ADDR_JOY1        = 16'h4016;
  localparam logic [15:0] ADDR_JOY2        = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h40;
  localparam int          NUM_PADS         = 2;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/controller_ports_if.sv
// CPU-side bus bundle: the CPU is master, the controller-port block is slave.
interface controller_ports_if;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (output addr, rw, data_in, input data_out, data_oe);
  modport slave  (input addr, rw, data_in, output data_out, data_oe);
endinterface

// File: rtl/joypad_shifter.sv
// 4021-style parallel-in/serial-out register; ones fill in from the top so
// reads past the eighth button return 1.
module joypad_shifter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       serial_out
);

  logic [7:0] sr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_reg <= 8'hFF;
    end else if (load) begin
      sr_reg <= buttons;
    end else if (shift) begin
      sr_reg <= {1'b1, sr_reg[7:1]};
    end
  end

  assign serial_out = sr_reg[0];

endmodule

// File: rtl/controller_ports.sv
// Controller-port responder: decodes $4016 writes into the strobe latch and
// serves one serial button bit per read of $4016/$4017.
module controller_ports
  import controller_pkg::*;
#(
  parameter logic [15:0] ADDR_PORT0 = ADDR_JOY1,
  parameter logic [15:0] ADDR_PORT1 = ADDR_JOY2,
  parameter logic [7:0]  OPEN_BUS   = OPEN_BUS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  controller_ports_if.slave  bus,
  input  logic [7:0]         pad0_buttons,
  input  logic [7:0]         pad1_buttons,
  output logic               strobe
);

  logic              strobe_reg;
  logic              strobe_write;
  logic [7:0]        pad_buttons [NUM_PADS];
  logic [15:0]       port_addr   [NUM_PADS];
  logic [NUM_PADS-1:0] port_sel;
  logic [NUM_PADS-1:0] port_serial;
  logic [NUM_PADS-1:0] port_bit;
  logic              unused_data_in;

  assign pad_buttons[0] = pad0_buttons;
  assign pad_buttons[1] = pad1_buttons;
  assign port_addr[0]   = ADDR_PORT0;
  assign port_addr[1]   = ADDR_PORT1;

  // Only $4016 owns the latch; $4017 writes belong to the APU frame counter.
  assign strobe_write   = !bus.rw && (bus.addr == ADDR_PORT0);
  assign unused_data_in = ^bus.data_in[7:1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_reg <= 1'b0;
    end else if (strobe_write) begin
      strobe_reg <= bus.data_in[0];
    end
  end

  assign strobe = strobe_reg;

  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_port
      assign port_sel[gi] = bus.rw && (bus.addr == port_addr[gi]);

      joypad_shifter u_shifter (
        .clock      (clock),
        .reset      (reset),
        .load       (strobe_reg),
        .shift      (!strobe_reg && port_sel[gi]),
        .buttons    (pad_buttons[gi]),
        .serial_out (port_serial[gi])
      );

      // While strobed the pad is transparent, so A is seen live.
      assign port_bit[gi] = strobe_reg ? pad_buttons[gi][BTN_A] : port_serial[gi];
    end
  endgenerate

  always_comb begin
    bus.data_oe  = |port_sel;
    bus.data_out = 8'h00;
    if (port_sel[0]) begin
      bus.data_out = {OPEN_BUS[7:1], port_bit[0]};
    end else if (port_sel[1]) begin
      bus.data_out = {OPEN_BUS[7:1], port_bit[1]};
    end
  end

endmodule

// File: tb/tb_controller_ports.sv
// Randomized and directed bench for controller_ports with a queue-based
// scoreboard fed by a latched-buttons/read-count reference model.
module tb_controller_ports;

  typedef struct {
    logic       oe;
    logic [7:0] d;
    logic       stb;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] pad0;
  logic [7:0] pad1;
  logic       strobe;

  controller_ports_if bus ();

  controller_ports dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .pad0_buttons (pad0),
    .pad1_buttons (pad1),
    .strobe       (strobe)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // Reference model: buttons latched at the last strobed edge plus the
  // number of reads each port has served since then.
  logic       m_strobe;
  logic [7:0] m_latched [2];
  int         m_cnt     [2];

  function automatic logic model_bit(int n, logic [7:0] pad);
    logic [7:0] l;
    if (m_strobe) return pad[0];
    if (m_cnt[n] >= 8) return 1'b1;
    l = m_latched[n];
    return l[m_cnt[n]];
  endfunction

  task automatic model_reset();
    m_strobe     = 1'b0;
    m_latched[0] = 8'hFF;
    m_latched[1] = 8'hFF;
    m_cnt[0]     = 0;
    m_cnt[1]     = 0;
  endtask

  task automatic cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
    exp_t e;
    int   n;
    bus.addr    = a;
    bus.rw      = r;
    bus.data_in = d;
    n = -1;
    if (r && a == 16'h4016) n = 0;
    else if (r && a == 16'h4017) n = 1;
    e.oe  = (n >= 0);
    e.d   = (n < 0) ? 8'h00 : {7'b0100000, model_bit(n, (n == 0) ? pad0 : pad1)};
    e.stb = m_strobe;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (!reset) begin
      if (m_strobe) begin
        m_latched[0] = pad0;
        m_latched[1] = pad1;
        m_cnt[0]     = 0;
        m_cnt[1]     = 0;
      end else if (n >= 0) begin
        if (m_cnt[n] < 8) m_cnt[n] = m_cnt[n] + 1;
      end
      if (!r && a == 16'h4016) m_strobe = d[0];
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    cycle(16'h0000, 1'b1, 8'h00);
    reset = 1'b0;
  endtask

  task automatic latch_pads(input logic [7:0] p0, input logic [7:0] p1);
    pad0 = p0;
    pad1 = p1;
    cycle(16'h4016, 1'b0, 8'h01);
    cycle(16'h4016, 1'b0, 8'h00);
  endtask

  // Monitor: one expected entry per bus cycle, compared mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.data_oe !== e.oe) begin
        bad++;
        $display("FAIL data_oe addr=%h rw=%b got=%b want=%b", bus.addr, bus.rw, bus.data_oe, e.oe);
      end
      total++;
      if (bus.data_out !== e.d) begin
        bad++;
        $display("FAIL data_out addr=%h rw=%b got=%h want=%h", bus.addr, bus.rw, bus.data_out, e.d);
      end
      total++;
      if (strobe !== e.stb) begin
        bad++;
        $display("FAIL strobe got=%b want=%b", strobe, e.stb);
      end
      $display("txn t=%0t addr=%h rw=%b din=%h rst=%b out=%h oe=%b stb=%b",
               $time, bus.addr, bus.rw, bus.data_in, reset, bus.data_out, bus.data_oe, strobe);
    end
  end

  initial begin
    reset       = 1'b1;
    pad0        = 8'h00;
    pad1        = 8'h00;
    bus.addr    = 16'h0000;
    bus.rw      = 1'b1;
    bus.data_in = 8'h00;
    model_reset();
    cycle(16'h0000, 1'b1, 8'h00);
    cycle(16'h0000, 1'b1, 8'h00);
    reset = 1'b0;

    // No strobe since reset: every read is 8'h41, idle cycles between.
    for (int i = 0; i < 9; i++) begin
      cycle(16'h4016, 1'b1, 8'h00);
      cycle(16'h0000, 1'b1, 8'h00);
    end

    // Full A..Right sequence plus the trailing 1.
    latch_pads(8'b1000_0101, 8'h00);
    for (int i = 0; i < 9; i++) cycle(16'h4016, 1'b1, 8'h00);

    // Strobe held high: reads follow pad0[0] live.
    cycle(16'h4016, 1'b0, 8'h01);
    for (int i = 0; i < 6; i++) begin
      pad0 = {7'b0, i[0]};
      cycle(16'h4016, 1'b1, 8'h00);
    end
    pad0 = 8'h01;
    cycle(16'h4016, 1'b0, 8'h00);
    cycle(16'h4016, 1'b1, 8'h00);
    cycle(16'h4016, 1'b1, 8'h00);

    // Independent port advance.
    latch_pads(8'h01, 8'h02);
    cycle(16'h4016, 1'b1, 8'h00);
    cycle(16'h4017, 1'b1, 8'h00);
    cycle(16'h4017, 1'b1, 8'h00);
    cycle(16'h4016, 1'b1, 8'h00);

    // $4017 write leaves strobe alone; unrelated address stays quiet.
    cycle(16'h4017, 1'b0, 8'hFF);
    cycle(16'h4016, 1'b1, 8'h00);
    cycle(16'h5000, 1'b1, 8'h00);
    cycle(16'h4016, 1'b0, 8'hFE);

    // Reset mid-sequence, then restart from A.
    latch_pads(8'hA6, 8'h5B);
    for (int i = 0; i < 3; i++) cycle(16'h4016, 1'b1, 8'h00);
    pulse_reset();
    cycle(16'h4016, 1'b1, 8'h00);
    cycle(16'h4017, 1'b1, 8'h00);
    latch_pads(8'hA6, 8'h5B);
    for (int i = 0; i < 9; i++) cycle(16'h4016, 1'b1, 8'h00);

    // Randomized bus traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      int          pick;
      if ($urandom_range(0, 3) == 0) pad0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pad1 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        pick = $urandom_range(0, 4);
        case (pick)
          0, 1:    a = 16'h4016;
          2:       a = 16'h4017;
          3:       a = 16'h5000;
          default: a = 16'($urandom);
        endcase
        cycle(a, ($urandom_range(0, 2) != 0), 8'($urandom));
      end
    end

    bus.rw   = 1'b1;
    bus.addr = 16'h0000;
    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller_ports.md
# controller_ports

Bus responder for the two standard controller ports on the 2A03 CPU bus. It decodes CPU writes to $4016, which drive the strobe/OUT0 latch, and CPU reads of $4016 and $4017, which return one serial button bit per read. Internally it emulates a pair of 4021-style parallel-in/serial-out shift registers loaded from parallel button inputs. It sits beside main memory on the CPU's addr/data/rw bus and is the other end of the CPU's controller-port accesses.

## Interface
Parameters:
- ADDR_PORT0, 16'h4016: strobe write address; port 0 read address.
- ADDR_PORT1, 16'h4017: port 1 read address. Writes here are ignored, because the APU frame counter owns them.
- OPEN_BUS, 8'h40: value driven on data_out[7:1] during a port read; bit 0 of this constant is ignored.

Ports:
- clock  in  1  CPU clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- addr  in  16  CPU address.
- rw  in  1  1 = read, 0 = write.
- data_in  in  8  CPU write data.
- data_out  out  8  read data; valid only while data_oe=1, otherwise 8'h00.
- data_oe  out  1  1 while this block drives the bus.
- pad0_buttons  in  8  port 0 buttons, 1 = pressed. Bit order: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- pad1_buttons  in  8  port 1 buttons, same order.
- strobe  out  1  current OUT0 latch value.

## Operation
- Write cycle (rw=0, addr=ADDR_PORT0): strobe <= data_in[0]. data_in[7:1] is ignored. data_oe=0.
- Read cycle on port N (rw=1, addr=ADDR_PORTN):
  - data_oe=1.
  - data_out = {OPEN_BUS[7:1], bitN}.
  - When strobe=1, bitN = padN_buttons[0], taken live.
  - When strobe=0, bitN = srN[0].
- While strobe=1, both shift registers reload every cycle from their button inputs (sr <= buttons). No shifting happens.
- While strobe=0:
  - A read of port N shifts only srN at the end of that cycle: srN <= {1'b1, srN[7:1]}.
  - The other register holds.
- Read order after strobe goes 1→0 is A, B, Select, Start, Up, Down, Left, Right. Every read after the 8th returns 1.
- Strobe falling edge: the register keeps the value loaded on the last cycle strobe was 1. The value is frozen from that point.
- Any other address, or a write to ADDR_PORT1: no state change, data_oe=0, data_out=0.
- Reset values: strobe=0, sr0=sr1=8'hFF, data_oe=0, data_out=0.

## Timing
- data_out and data_oe are combinational from addr, rw and the register state. They are valid in the same cycle the CPU presents the address, with zero-cycle read latency.
- The shift, strobe update and reload take effect at the posedge that ends the access cycle. The CPU samples the pre-edge value, so exactly one bit is consumed per read cycle.
- A read held over K consecutive cycles counts as K reads and shifts K times. This matches the bus, where each CPU cycle is one access.
- Write of strobe=1 followed by a read on the next cycle: the read returns buttons[0] live.
- Write of strobe=0 followed by a read on the next cycle: the read returns the A bit loaded at the write edge.
- Reset asserted mid-sequence: registers return to 8'hFF immediately. Reads then return 1 until the next strobe.

## Structure
- Package controller_pkg holds:
  - ADDR_JOY1 / ADDR_JOY2 constants.
  - Button index constants (BTN_A … BTN_RIGHT).
  - The OPEN_BUS default.
- Sub-module joypad_shifter is instantiated twice. It contains the 8-bit register with load, shift and serial_out, and the top-level block drives its load and shift inputs. The top level holds the address decode, the strobe latch and the output mux.

## Test plan
- Reset, then read $4016 9 times with no strobe → data_out=8'h41 every read; data_oe=1 only on read cycles.
- pad0=8'b1000_0101, write $4016=1 then $4016=0, then 9 reads of $4016 → bit0 sequence 1,0,1,0,0,0,0,1,1.
- Strobe held at 1, pad0[0] toggles between reads → each read returns the live pad0[0]; a subsequent 0-strobe read still starts at A.
- Interleave reads: pad0=8'h01, pad1=8'h02, latch, then reads $4016,$4017,$4017,$4016 → bits 1,0,1,0. Each port advances independently.
- Write $4017=8'hFF, then read $4016 → strobe unchanged, data_oe=0 during the write, no shift. Then read $5000 → data_oe=0, data_out=0.
- Reset pulsed after 3 of 8 reads → the next read returns 1; after re-strobe, the sequence restarts at A.
